// File: rtl/overlap_add_stream.sv
// overlap_add_stream: AAC overlap-add stage that adds the stored previous second half to the current first half.
// Ports:
//   clock, reset (async, active-high), clear (sync wipe of overlap memory, frame state and error)
//   in_valid/in_ready/in_sof/in_ch/in_data : windowed frame beats, LANES samples of WORD bits each
//   out_valid/out_ready/out_sof/out_ch/out_data : saturated overlap-added beats (first half only)
//   error : sticky protocol error (sof mid-frame, missing sof, channel out of range)
module overlap_add_stream #(
    parameter int WORD  = 16,
    parameter int LANES = 4,
    parameter int HALF  = 512,
    parameter int NCH   = 2,
    parameter int CHW   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sof,
    input  logic [CHW-1:0]         in_ch,
    input  logic [LANES*WORD-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic [CHW-1:0]         out_ch,
    output logic [LANES*WORD-1:0]  out_data,
    output logic                   error
);
    localparam int BPH = HALF / LANES;
    localparam int BPF = 2 * BPH;
    localparam int BW  = $clog2(BPF);
    localparam int AW  = (NCH * BPH > 1) ? $clog2(NCH * BPH) : 1;
    localparam logic [BW-1:0] BPH_B = BW'(BPH);
    localparam logic [BW-1:0] LAST  = BW'(BPF - 1);

    logic [LANES*WORD-1:0] mem [NCH*BPH];
    logic [BW-1:0]         bcnt, eb, bidx;
    logic [CHW-1:0]        ch, cur_ch;
    logic                  phase_a, acc, vb, bad_ch;
    logic [AW-1:0]         addr;
    logic [LANES*WORD-1:0] ovl, sum;

    // A sof beat always restarts the frame, so its effective beat index is 0.
    always_comb begin
        eb       = in_sof ? '0 : bcnt;
        phase_a  = eb < BPH_B;
        bad_ch   = 32'(in_ch) >= NCH;
        cur_ch   = in_sof ? (bad_ch ? '0 : in_ch) : ch;
        bidx     = phase_a ? eb : eb - BPH_B;
        addr     = AW'(cur_ch) * AW'(BPH) + AW'(bidx);
        ovl      = mem[addr];
        in_ready = !clear && (!phase_a || !out_valid || out_ready);
        acc      = in_valid && in_ready;
        vb       = acc && (in_sof || bcnt != '0);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [WORD:0] s;
        assign s = $signed({in_data[(g+1)*WORD-1], in_data[g*WORD +: WORD]})
                 + $signed({ovl[(g+1)*WORD-1], ovl[g*WORD +: WORD]});
        // Top two bits disagree only on overflow; clamp toward the sign of the true sum.
        assign sum[g*WORD +: WORD] = (s[WORD] != s[WORD-1]) ? {s[WORD], {(WORD-1){~s[WORD]}}} : s[WORD-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH*BPH; i++) mem[i] <= '0;
            bcnt      <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            error     <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NCH*BPH; i++) mem[i] <= '0;
            bcnt      <= '0;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (acc && (in_sof ? (bcnt != '0 || bad_ch) : bcnt == '0)) error <= 1'b1;
            if (vb) begin
                bcnt <= (eb == LAST) ? '0 : eb + 1'b1;
                if (in_sof) ch <= cur_ch;
            end
            if (vb && phase_a) begin
                out_valid <= 1'b1;
                out_sof   <= eb == '0;
                out_ch    <= cur_ch;
                out_data  <= sum;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (vb && !phase_a) mem[addr] <= in_data;
        end
    end
endmodule
